ex_mem_stage: RTL

- EX/MEM pipeline stage sitting directly downstream of the ALU in the 5-stage MIPS datapath.
- Registers the ALU result, flags and control fields, and resolves conditional branches from the registered zero flag.
- Runs the data-memory request handshake and holds the pipeline (stall_req) until the access completes.
- Feeds the MEM/WB latch and the hazard/forwarding unit.

---
 rtl/cpu_types_pkg.sv | 40 ++++
 rtl/ex_mem_stage_if.sv | 41 ++++
 rtl/branch_resolve.sv | 31 +++
 rtl/ex_mem_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared datapath types for the 5-stage MIPS pipeline.
//   - word_t / regbits_t : datapath word and register-select types
//   - brtype_t           : conditional branch kind carried down the pipe
//   - exmem_state_t      : EX/MEM memory-handshake FSM states
//   - br_cond()          : branch condition from branch kind and zero flag
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  localparam int WORD_W    = 32;
  localparam int REG_SEL_W = 5;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [REG_SEL_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2
  } brtype_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } exmem_state_t;

  // True when the branch kind is satisfied by the ALU zero flag.
  function automatic logic br_cond(input brtype_t brtype, input logic zero);
    logic hit;
    hit = 1'b0;
    case (brtype)
      BR_EQ:   hit = zero;
      BR_NE:   hit = ~zero;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// -----------------------------------------------------------------------------
// ex_mem_stage_if
//   Data-memory request/response bus between the EX/MEM stage and the
//   memory controller.
//   - dmemREN / dmemWEN : read / write request (never both high)
//   - dmemaddr          : access address
//   - dmemstore         : store data
//   - dhit              : access complete this cycle
//   - dmemload          : load data, valid with dhit
//   Modports: master = pipeline stage, slave = memory side.
// -----------------------------------------------------------------------------
interface ex_mem_stage_if #(
  parameter int WORD_W = 32
);

  logic              dmemREN;
  logic              dmemWEN;
  logic [WORD_W-1:0] dmemaddr;
  logic [WORD_W-1:0] dmemstore;
  logic              dhit;
  logic [WORD_W-1:0] dmemload;

  modport master (
    output dmemREN,
    output dmemWEN,
    output dmemaddr,
    output dmemstore,
    input  dhit,
    input  dmemload
  );

  modport slave (
    input  dmemREN,
    input  dmemWEN,
    input  dmemaddr,
    input  dmemstore,
    output dhit,
    output dmemload
  );

endinterface

// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
//   Purely combinational conditional-branch resolution. Reusable by an
//   early-branch variant that resolves from unregistered fields.
//   Ports:
//     valid      in   instruction is real
//     brtype     in   branch kind
//     zero       in   ALU zero flag
//     target_in  in   computed branch target
//     taken      out  branch is taken
//     target     out  redirect address
// -----------------------------------------------------------------------------
module branch_resolve
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              valid,
  input  brtype_t           brtype,
  input  logic              zero,
  input  logic [WORD_W-1:0] target_in,
  output logic              taken,
  output logic [WORD_W-1:0] target
);

  always_comb begin
    taken  = valid & br_cond(brtype, zero);
    target = target_in;
  end

endmodule

// File: rtl/ex_mem_stage.sv
// -----------------------------------------------------------------------------
// ex_mem_stage
//   EX/MEM pipeline register of the 5-stage MIPS datapath. Latches the ALU
//   result, flags and control fields, resolves conditional branches from the
//   registered zero flag, and runs the data-memory handshake, holding the
//   pipeline (stall_req) until the access completes.
//
//   Ports:
//     CLK, nRST        clock (rising edge), asynchronous active-low reset
//     ex_*             EX-stage instruction fields and control bits
//     flush            squash the EX instruction (load a bubble)
//     dmem             data-memory bus (master side)
//     mem_*            registered fields towards MEM/WB and forwarding
//     branch_taken     conditional branch resolved taken
//     branch_target    registered branch target
//     stall_req        pipeline hold while a memory access is pending
//     ovf_exc          one-cycle overflow exception pulse
//
//   Build option:
//     EX_MEM_OVF_TRAP_EN  trapping ADD/SUB overflow suppresses register write
//                         and memory access and raises ovf_exc. Without it
//                         overflow is ignored and ovf_exc stays 0.
// -----------------------------------------------------------------------------
module ex_mem_stage
  import cpu_types_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int REG_SEL_W = 5
) (
  input  logic                 CLK,
  input  logic                 nRST,

  input  logic                 ex_valid,
  input  logic [WORD_W-1:0]    ex_aluout,
  input  logic                 ex_zero,
  input  logic                 ex_overflow,
  input  logic                 ex_trap_ovf,
  input  logic [WORD_W-1:0]    ex_storedata,
  input  logic [REG_SEL_W-1:0] ex_wsel,
  input  logic                 ex_regwen,
  input  logic                 ex_dren,
  input  logic                 ex_dwen,
  input  logic                 ex_memtoreg,
  input  logic                 ex_halt,
  input  logic [1:0]           ex_brtype,
  input  logic [WORD_W-1:0]    ex_brtarget,
  input  logic [WORD_W-1:0]    ex_npc,
  input  logic                 flush,

  ex_mem_stage_if.master       dmem,

  output logic                 mem_valid,
  output logic                 mem_regwen,
  output logic                 mem_memtoreg,
  output logic                 mem_halt,
  output logic [WORD_W-1:0]    mem_aluout,
  output logic [WORD_W-1:0]    mem_load,
  output logic [WORD_W-1:0]    mem_npc,
  output logic [REG_SEL_W-1:0] mem_wsel,
  output logic                 branch_taken,
  output logic [WORD_W-1:0]    branch_target,
  output logic                 stall_req,
  output logic                 ovf_exc
);

  typedef struct packed {
    logic                 valid;
    logic [WORD_W-1:0]    aluout;
    logic                 zero;
    logic [WORD_W-1:0]    storedata;
    logic [REG_SEL_W-1:0] wsel;
    logic                 regwen;
    logic                 dren;
    logic                 dwen;
    logic                 memtoreg;
    brtype_t              brtype;
    logic [WORD_W-1:0]    brtarget;
    logic [WORD_W-1:0]    npc;
  } fields_t;

  exmem_state_t      state_q, state_d;
  fields_t           fld_q, fld_d;
  logic              halt_q, halt_d;
  logic [WORD_W-1:0] load_q, load_d;
  logic              ovf_exc_q, ovf_exc_d;

  logic in_access;
  logic stall;
  logic capture;
  logic take;
  logic trap_hit;

`ifdef EX_MEM_OVF_TRAP_EN
  assign trap_hit = ex_trap_ovf & ex_overflow;
`else
  logic unused_ovf;
  assign trap_hit   = 1'b0;
  assign unused_ovf = ex_trap_ovf ^ ex_overflow;
`endif

  always_comb begin
    in_access = (state_q == ACCESS);
    stall     = in_access & ~dmem.dhit;
    // The completing edge of an access also captures the next instruction.
    capture   = ~stall;
    take      = ex_valid & ~flush;

    state_d   = state_q;
    fld_d     = fld_q;
    halt_d    = halt_q;
    load_d    = load_q;
    ovf_exc_d = 1'b0;

    if (in_access && dmem.dhit && fld_q.dren) begin
      load_d = dmem.dmemload;
    end

    if (capture) begin
      fld_d = '0;
      if (take) begin
        fld_d.valid     = 1'b1;
        fld_d.aluout    = ex_aluout;
        fld_d.zero      = ex_zero;
        fld_d.storedata = ex_storedata;
        fld_d.wsel      = ex_wsel;
        fld_d.regwen    = ex_regwen & ~trap_hit;
        // Store wins when both request bits are set; after halt, or on a
        // trapped overflow, no memory request is raised at all.
        fld_d.dwen      = ex_dwen & ~halt_q & ~trap_hit;
        fld_d.dren      = ex_dren & ~ex_dwen & ~halt_q & ~trap_hit;
        fld_d.memtoreg  = ex_memtoreg;
        fld_d.brtype    = brtype_t'(ex_brtype);
        fld_d.brtarget  = ex_brtarget;
        fld_d.npc       = ex_npc;
        halt_d          = halt_q | ex_halt;
        ovf_exc_d       = trap_hit;
      end
      // Going straight back into ACCESS keeps back-to-back memory ops
      // from losing the instruction captured on the completing edge.
      state_d = (fld_d.dren | fld_d.dwen) ? ACCESS : IDLE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      fld_q     <= '0;
      halt_q    <= 1'b0;
      load_q    <= '0;
      ovf_exc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fld_q     <= fld_d;
      halt_q    <= halt_d;
      load_q    <= load_d;
      ovf_exc_q <= ovf_exc_d;
    end
  end

  assign mem_valid    = fld_q.valid;
  assign mem_regwen   = fld_q.regwen;
  assign mem_memtoreg = fld_q.memtoreg;
  assign mem_halt     = halt_q;
  assign mem_aluout   = fld_q.aluout;
  assign mem_load     = load_q;
  assign mem_npc      = fld_q.npc;
  assign mem_wsel     = fld_q.wsel;
  assign stall_req    = stall;
  assign ovf_exc      = ovf_exc_q;

  assign dmem.dmemREN   = in_access & fld_q.dren;
  assign dmem.dmemWEN   = in_access & fld_q.dwen;
  assign dmem.dmemaddr  = in_access ? fld_q.aluout    : '0;
  assign dmem.dmemstore = in_access ? fld_q.storedata : '0;

  branch_resolve #(
    .WORD_W (WORD_W)
  ) u_branch_resolve (
    .valid     (fld_q.valid),
    .brtype    (fld_q.brtype),
    .zero      (fld_q.zero),
    .target_in (fld_q.brtarget),
    .taken     (branch_taken),
    .target    (branch_target)
  );

endmodule
